// File: rtl/ev_axis_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ev_axis_pkg : shared types and status-word bit positions                 |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package ev_axis_pkg;

  typedef enum logic {
    STREAM = 1'b0,
    SAMPLE = 1'b1
  } mode_e;

  localparam int NEW_DATA_BIT  = 31;
  localparam int NOT_CONN_BIT  = 30;
  localparam int COALESCED_BIT = 29;
  localparam int CH_MSB        = 28;

  // A single channel still needs one id bit in the status word.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ev_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ev_sync_fifo : show-ahead synchronous FIFO with registered occupancy     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module ev_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign level_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];

  // A pop at full frees a slot, so a same-cycle push may still land.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/event_to_axis_status.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | event_to_axis_status : per-channel event capture, round-robin arbiter,   |
// |                        FIFO and AXI-Stream / sample-register output      |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module event_to_axis_status
  import ev_axis_pkg::*;
#(
  parameter int    N_CH   = 2,
  parameter int    DATA_W = 25,
  parameter int    DEPTH  = 8,
  parameter mode_e MODE   = STREAM
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ev_valid,
  input  logic [N_CH*DATA_W-1:0]   ev_data,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int CH_W  = ch_width(N_CH);
  localparam int ENT_W = 1 + CH_W + DATA_W;

  logic [N_CH-1:0]   pend_vld_q,  pend_vld_d;
  logic [N_CH-1:0]   pend_coal_q, pend_coal_d;
  logic [DATA_W-1:0] pend_data_q [N_CH];
  logic [DATA_W-1:0] pend_data_d [N_CH];
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic              nc_q, nc_d;

  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_id;
  logic [CH_W-1:0]   w_scan;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [ENT_W-1:0]  w_push_word;
  logic [ENT_W-1:0]  w_head;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return (int'(ch) >= N_CH - 1) ? '0 : ch + CH_W'(1);
  endfunction

  // FIFO entry is {coalesced, id, payload}; status-word bits are placed here.
  function automatic logic [31:0] pack_word(input logic nd, input logic nc,
                                            input logic [ENT_W-1:0] ent);
    logic [31:0] w;
    w                      = '0;
    w[NEW_DATA_BIT]        = nd;
    w[NOT_CONN_BIT]        = nc;
    w[COALESCED_BIT]       = ent[ENT_W-1];
    w[CH_MSB -: CH_W]      = ent[DATA_W +: CH_W];
    w[DATA_W-1:0]          = ent[DATA_W-1:0];
    return w;
  endfunction

  always_comb begin : arbiter
    w_gnt_vld = 1'b0;
    w_gnt_id  = last_grant_q;
    w_scan    = next_ch(last_grant_q);
    for (int k = 0; k < N_CH; k++) begin
      if (!w_gnt_vld && pend_vld_q[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_scan;
      end
      w_scan = next_ch(w_scan);
    end
    if (w_fifo_full) w_gnt_vld = 1'b0;
  end

  assign w_push_word = {pend_coal_q[w_gnt_id], w_gnt_id, pend_data_q[w_gnt_id]};

  always_comb begin : capture
    pend_vld_d  = pend_vld_q;
    pend_coal_d = pend_coal_q;
    pend_data_d = pend_data_q;
    for (int i = 0; i < N_CH; i++) begin
      if (ev_valid[i]) begin
        pend_vld_d[i]  = 1'b1;
        pend_data_d[i] = ev_data[i*DATA_W +: DATA_W];
        // Overwriting an entry that did not leave this cycle loses it.
        pend_coal_d[i] = pend_vld_q[i] && !(w_gnt_vld && (w_gnt_id == CH_W'(i)));
      end else if (w_gnt_vld && (w_gnt_id == CH_W'(i))) begin
        pend_vld_d[i]  = 1'b0;
        pend_coal_d[i] = 1'b0;
      end
    end
    last_grant_d = w_gnt_vld ? w_gnt_id : last_grant_q;
    nc_d         = nc_q && !(|ev_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q   <= '0;
      pend_coal_q  <= '0;
      for (int i = 0; i < N_CH; i++) pend_data_q[i] <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
      nc_q         <= 1'b1;
    end else begin
      pend_vld_q   <= pend_vld_d;
      pend_coal_q  <= pend_coal_d;
      pend_data_q  <= pend_data_d;
      last_grant_q <= last_grant_d;
      nc_q         <= nc_d;
    end
  end

  ev_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_gnt_vld),
    .push_data_i (w_push_word),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .empty_o     (w_fifo_empty),
    .full_o      (w_fifo_full),
    .level_o     (fifo_level)
  );

  if (MODE == STREAM) begin : g_stream
    assign w_pop         = !w_fifo_empty && m_axis_tready;
    assign m_axis_tvalid = !w_fifo_empty;
    assign m_axis_tdata  = w_fifo_empty ? pack_word(1'b0, nc_q, '0)
                                        : pack_word(1'b0, nc_q, w_head);
  end else begin : g_sample
    logic             nd_q,  nd_d;
    logic [ENT_W-1:0] smp_q, smp_d;

    assign w_pop = !w_fifo_empty;

    // A fresh word takes priority over the reader's acknowledge.
    always_comb begin
      nd_d  = nd_q;
      smp_d = smp_q;
      if (w_pop) begin
        nd_d  = 1'b1;
        smp_d = w_head;
      end else if (m_axis_tready) begin
        nd_d  = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        nd_q  <= 1'b0;
        smp_q <= '0;
      end else begin
        nd_q  <= nd_d;
        smp_q <= smp_d;
      end
    end

    assign m_axis_tvalid = 1'b1;
    assign m_axis_tdata  = pack_word(nd_q, nc_q, smp_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_event_to_axis_status.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_event_to_axis_status : directed vector bench, STREAM and SAMPLE DUTs  |
// | Revision                : 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_event_to_axis_status;
  import ev_axis_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_ev,  m_ev;
  logic [49:0] s_data, m_data;
  logic        s_rdy, m_rdy;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, m_tvalid;
  logic [2:0]  s_lvl, m_lvl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  event_to_axis_status #(.N_CH(2), .DATA_W(25), .DEPTH(4), .MODE(STREAM)) u_stream (
    .clk           (clk),
    .reset         (rst),
    .ev_valid      (s_ev),
    .ev_data       (s_data),
    .m_axis_tdata  (s_tdata),
    .m_axis_tvalid (s_tvalid),
    .m_axis_tready (s_rdy),
    .fifo_level    (s_lvl)
  );

  event_to_axis_status #(.N_CH(2), .DATA_W(25), .DEPTH(4), .MODE(SAMPLE)) u_sample (
    .clk           (clk),
    .reset         (rst),
    .ev_valid      (m_ev),
    .ev_data       (m_data),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_rdy),
    .fifo_level    (m_lvl)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  ev;
    logic [24:0] d0;
    logic [24:0] d1;
    logic        rdy;
    logic        chk;
    logic        vld;
    logic [31:0] data;
    logic [2:0]  lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] ev, input logic [24:0] d0,
                     input logic [24:0] d1, input logic rdy, input logic chk,
                     input logic vld, input logic [31:0] data, input logic [2:0] lvl);
    vec_t v;
    v.rst = r; v.ev = ev; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.chk = chk; v.vld = vld; v.data = data; v.lvl = lvl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic av, input logic [31:0] ad,
                       input logic [2:0] al, input logic ev, input logic [31:0] ed,
                       input logic [2:0] el);
    n_vec++;
    if (av !== ev || ad !== ed || al !== el) begin
      n_err++;
      $display("FAIL %s: got tvalid=%0b tdata=%08h level=%0d, expected tvalid=%0b tdata=%08h level=%0d",
               name, av, ad, al, ev, ed, el);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] ev, input logic [24:0] d0,
                     input logic [24:0] d1, input logic rdy);
    @(negedge clk);
    rst = r; s_ev = ev; s_data = {d1, d0}; s_rdy = rdy;
    m_ev = 2'b00; m_data = '0; m_rdy = 1'b0;
    #1;
  endtask

  task automatic mcyc(input logic [1:0] ev, input logic [24:0] d0,
                      input logic [24:0] d1, input logic rdy);
    @(negedge clk);
    rst = 1'b0; s_ev = 2'b00; s_data = '0; s_rdy = 1'b0;
    m_ev = ev; m_data = {d1, d0}; m_rdy = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1; s_ev = '0; s_data = '0; s_rdy = 1'b0;
    m_ev = '0; m_data = '0; m_rdy = 1'b0;

    // rst ev d0 d1 rdy | chk vld data lvl  (outputs observed in the same cycle)
    add(1, 2'b00, 0, 0, 1,  0, 0, 32'h0, 0);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h4000_0000, 0);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h4000_0000, 0);
    add(0, 2'b01, 25'h1ABCDEF, 0, 1, 1, 0, 32'h4000_0000, 0);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h0000_0000, 0);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h01AB_CDEF, 1);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h0000_0000, 0);
    // both channels every third cycle: ids must alternate 0,1
    add(1, 2'b00, 0, 0, 1,  0, 0, 32'h0, 0);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h4000_0000, 0);
    add(0, 2'b11, 25'h10, 25'h11, 1, 1, 0, 32'h4000_0000, 0);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h0000_0000, 0);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h0000_0010, 1);
    add(0, 2'b11, 25'h20, 25'h21, 1, 1, 1, 32'h1000_0011, 1);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h0000_0000, 0);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h0000_0020, 1);
    add(0, 2'b11, 25'h30, 25'h31, 1, 1, 1, 32'h1000_0021, 1);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h0000_0000, 0);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h0000_0030, 1);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h1000_0031, 1);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h0000_0000, 0);
    // six back-to-back ch1 events with the consumer stalled
    add(0, 2'b10, 0, 25'd1, 0, 1, 0, 32'h0000_0000, 0);
    add(0, 2'b10, 0, 25'd2, 0, 1, 0, 32'h0000_0000, 0);
    add(0, 2'b10, 0, 25'd3, 0, 1, 1, 32'h1000_0001, 1);
    add(0, 2'b10, 0, 25'd4, 0, 1, 1, 32'h1000_0001, 2);
    add(0, 2'b10, 0, 25'd5, 0, 1, 1, 32'h1000_0001, 3);
    add(0, 2'b10, 0, 25'd6, 0, 1, 1, 32'h1000_0001, 4);
    add(0, 2'b00, 0, 0, 0,  1, 1, 32'h1000_0001, 4);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h1000_0001, 4);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h1000_0002, 3);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h1000_0003, 3);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h1000_0004, 2);
    add(0, 2'b00, 0, 0, 1,  1, 1, 32'h3000_0006, 1);
    add(0, 2'b00, 0, 0, 1,  1, 0, 32'h0000_0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].ev, vecs[i].d0, vecs[i].d1, vecs[i].rdy);
      if (vecs[i].chk)
        check($sformatf("stream_vec%0d", i), s_tvalid, s_tdata, s_lvl,
              vecs[i].vld, vecs[i].data, vecs[i].lvl);
    end

    // SAMPLE mode: hold, acknowledge, then a pop that coincides with tready
    mcyc(2'b00, 0, 0, 0);       check("sample_reset",  m_tvalid, m_tdata, m_lvl, 1, 32'h4000_0000, 0);
    mcyc(2'b01, 25'h5, 0, 0);   check("sample_ev",     m_tvalid, m_tdata, m_lvl, 1, 32'h4000_0000, 0);
    mcyc(2'b00, 0, 0, 0);       check("sample_c1",     m_tvalid, m_tdata, m_lvl, 1, 32'h0000_0000, 0);
    mcyc(2'b00, 0, 0, 0);       check("sample_c2",     m_tvalid, m_tdata, m_lvl, 1, 32'h0000_0000, 1);
    mcyc(2'b00, 0, 0, 0);       check("sample_c3",     m_tvalid, m_tdata, m_lvl, 1, 32'h8000_0005, 0);
    mcyc(2'b00, 0, 0, 0);       check("sample_hold1",  m_tvalid, m_tdata, m_lvl, 1, 32'h8000_0005, 0);
    mcyc(2'b00, 0, 0, 0);       check("sample_hold2",  m_tvalid, m_tdata, m_lvl, 1, 32'h8000_0005, 0);
    mcyc(2'b00, 0, 0, 1);       check("sample_ack",    m_tvalid, m_tdata, m_lvl, 1, 32'h8000_0005, 0);
    mcyc(2'b00, 0, 0, 1);       check("sample_clr",    m_tvalid, m_tdata, m_lvl, 1, 32'h0000_0005, 0);
    mcyc(2'b10, 0, 25'h7, 1);   check("sample_ev2",    m_tvalid, m_tdata, m_lvl, 1, 32'h0000_0005, 0);
    mcyc(2'b00, 0, 0, 1);       check("sample_ev2_c1", m_tvalid, m_tdata, m_lvl, 1, 32'h0000_0005, 0);
    mcyc(2'b00, 0, 0, 1);       check("sample_ev2_c2", m_tvalid, m_tdata, m_lvl, 1, 32'h0000_0005, 1);
    mcyc(2'b00, 0, 0, 1);       check("sample_newwin", m_tvalid, m_tdata, m_lvl, 1, 32'h9000_0007, 0);
    mcyc(2'b00, 0, 0, 1);       check("sample_clr2",   m_tvalid, m_tdata, m_lvl, 1, 32'h1000_0007, 0);

    // STREAM: reset with three words queued and an event in the reset cycle
    cyc(0, 2'b01, 25'd1, 0, 0); check("rst_q0", s_tvalid, s_tdata, s_lvl, 0, 32'h0000_0000, 0);
    cyc(0, 2'b01, 25'd2, 0, 0); check("rst_q1", s_tvalid, s_tdata, s_lvl, 0, 32'h0000_0000, 0);
    cyc(0, 2'b01, 25'd3, 0, 0); check("rst_q2", s_tvalid, s_tdata, s_lvl, 1, 32'h0000_0001, 1);
    cyc(0, 2'b00, 0, 0, 0);     check("rst_q3", s_tvalid, s_tdata, s_lvl, 1, 32'h0000_0001, 2);
    cyc(1, 2'b10, 0, 25'd9, 0); check("rst_q4", s_tvalid, s_tdata, s_lvl, 1, 32'h0000_0001, 3);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b00, 0, 0, 1);
      check($sformatf("rst_flush%0d", i), s_tvalid, s_tdata, s_lvl, 0, 32'h4000_0000, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
